// File: rtl/sda_rx_decoder.sv
//-----------------------------------------------------------------------------
// sda_rx_decoder
//
// Receive side of the two-wire scl/sda link. Both lines are synchronised to
// sclk. START/STOP conditions are detected on the synchronised samples, and
// NBITS data bits are shifted in MSB first on scl rising edges. A frame that
// is closed by a valid STOP updates the binary value and the one-hot decode.
// Premature STOPs, repeated STARTs and scl inactivity abort an open frame.
//
// Ports
//   sclk        sampling clock, rising edge
//   rst         asynchronous reset, active low
//   scl, sda    serial link inputs (sda is never driven here)
//   outhigh     one-hot decode of the last valid frame (2**NBITS wide)
//   data_out    binary value of the last valid frame
//   frame_valid one-cycle pulse when outhigh/data_out update
//   frame_err   one-cycle pulse when an open frame is aborted
//   busy        high while a frame is open
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no frame open; waiting for START
// RECV      | START seen; shifting in data bits
// WAIT_STOP | all data bits captured; trailing bits ignored until STOP
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module sda_rx_decoder #(
  parameter int NBITS       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda,
  output logic [2**NBITS-1:0]   outhigh,
  output logic [NBITS-1:0]      data_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int OW = 2**NBITS;
  localparam int CW = $clog2(NBITS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  // fewer than two stages would leave the pins metastability-exposed
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_STOP = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [SS-1:0]     scl_sync, sda_sync;
  logic              scl_s, sda_s, scl_d, sda_d;
  logic              start_c, stop_c, bit_c, scl_edge;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NBITS-1:0]  sreg, sreg_nx;
  logic [TW-1:0]     tcnt;
  logic              tc_hit;
  logic              valid_nx, err_nx;

  // Synchronisers and one-cycle-delayed copies; all reset to the idle-bus level.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SS-2:0], scl};
      sda_sync <= {sda_sync[SS-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SS-1];
  assign sda_s = sda_sync[SS-1];

  // START/STOP need scl high on two consecutive samples, so they can never
  // coincide with a bit strobe, which needs scl_d low.
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign bit_c    = scl_s & ~scl_d;
  assign scl_edge = scl_s ^ scl_d;

  // Inactivity timer: counts cycles without an scl edge while a frame is open,
  // saturating at TIMEOUT.
  assign tc_hit = (tcnt == TW'(TIMEOUT));

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (state == IDLE || scl_edge) begin
      tcnt <= '0;
    end else if (!tc_hit) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          state_nx = RECV;
          cnt_nx   = '0;
          sreg_nx  = '0;
        end
      end
      RECV: begin
        if (start_c) begin
          err_nx  = 1'b1;
          cnt_nx  = '0;
          sreg_nx = '0;
        end else if (stop_c) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (bit_c) begin
          sreg_nx = {sreg[NBITS-2:0], sda_s};
          cnt_nx  = cnt + CW'(1);
          if (cnt == CW'(NBITS - 1)) begin
            state_nx = WAIT_STOP;
          end
        end else if (tc_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_STOP: begin
        // scl rises here (the transmitter's trailing bit) are deliberately ignored
        if (start_c) begin
          err_nx   = 1'b1;
          state_nx = RECV;
          cnt_nx   = '0;
          sreg_nx  = '0;
        end else if (stop_c) begin
          valid_nx = 1'b1;
          state_nx = IDLE;
        end else if (!bit_c && tc_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      outhigh     <= '0;
      data_out    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sreg        <= sreg_nx;
      frame_valid <= valid_nx;
      frame_err   <= err_nx;
      busy        <= (state_nx != IDLE);
      if (valid_nx) begin
        data_out <= sreg;
        outhigh  <= OW'(1) << sreg;
      end
    end
  end

endmodule

// File: tb/tb_sda_rx_decoder.sv
`timescale 1ns/1ps

module tb_sda_rx_decoder;

  localparam int NBITS   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 255;
  localparam int OW      = 2**NBITS;

  logic              sclk;
  logic              rst;
  logic              scl;
  logic              sda;
  logic [OW-1:0]     outhigh;
  logic [NBITS-1:0]  data_out;
  logic              frame_valid;
  logic              frame_err;
  logic              busy;

  sda_rx_decoder #(.NBITS(NBITS), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .rst(rst), .scl(scl), .sda(sda),
    .outhigh(outhigh), .data_out(data_out),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk_eq(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  // Expected pulse: kind plus the output value that must be held afterwards.
  typedef struct packed {
    logic             err;
    logic             have;
    logic [NBITS-1:0] val;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: works on link-level events derived from the pin activity.
  bit               m_open = 0;
  bit               m_bits[$];
  bit               m_have = 0;
  logic [NBITS-1:0] m_last = '0;

  function automatic void push_err();
    exp_t e;
    e.err = 1'b1; e.have = m_have; e.val = m_last;
    exp_q.push_back(e);
  endfunction

  function automatic void m_start();
    if (m_open) push_err();
    m_open = 1;
    m_bits.delete();
  endfunction

  function automatic void m_bit(bit b);
    if (m_open) m_bits.push_back(b);
  endfunction

  function automatic void m_stop();
    exp_t e;
    int   v;
    if (m_open) begin
      if (m_bits.size() >= NBITS) begin
        v = 0;
        for (int i = 0; i < NBITS; i++) v = v * 2 + int'(m_bits[i]);
        m_have = 1;
        m_last = NBITS'(v);
        e.err = 1'b0; e.have = 1'b1; e.val = m_last;
        exp_q.push_back(e);
      end else begin
        push_err();
      end
    end
    m_open = 0;
  endfunction

  // Pin drivers: change pins on the falling sclk edge and feed the model.
  int      p = 2;
  int      since_scl = 0;
  longint  t_scl = 0;
  longint  t_sda_rise = 0;
  bit      to_check = 0;

  task automatic tick();
    @(negedge sclk);
    since_scl++;
    if (m_open && since_scl == TIMEOUT) begin
      push_err();
      m_open = 0;
    end
  endtask

  task automatic hold();
    repeat (p - 1) tick();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic set_scl(bit v);
    tick();
    if (v != scl) begin
      if (v) m_bit(sda);
      scl = v;
      since_scl = 0;
      t_scl = $time;
    end
  endtask

  task automatic set_sda(bit v);
    tick();
    if (scl && sda && !v) m_start();
    if (scl && !sda && v) begin
      m_stop();
      t_sda_rise = $time;
    end
    sda = v;
  endtask

  task automatic start_cond();
    if (!scl) begin
      set_sda(1); hold();
      set_scl(1); hold();
    end else if (!sda) begin
      set_sda(1); hold();
    end
    set_sda(0); hold();
    set_scl(0); hold();
  endtask

  task automatic send_bit(bit b);
    set_sda(b); hold();
    set_scl(1); hold();
    set_scl(0); hold();
  endtask

  task automatic stop_cond();
    set_sda(0); hold();
    set_scl(1); hold();
    set_sda(1); hold();
  endtask

  task automatic frame(logic [NBITS-1:0] v, int trail);
    start_cond();
    for (int i = NBITS - 1; i >= 0; i--) send_bit(v[i]);
    repeat (trail) send_bit(1'($urandom_range(0, 1)));
    stop_cond();
  endtask

  // Monitor / scoreboard
  int            n_valid = 0;
  int            n_err   = 0;
  logic [OW-1:0] prev_oh = '0;
  logic [NBITS-1:0] prev_dv = '0;
  bit            prev_pulse = 0;

  always @(negedge sclk) begin
    exp_t          e;
    logic [OW-1:0] eo;
    longint        lat;
    if (!rst) begin
      prev_oh    = '0;
      prev_dv    = '0;
      prev_pulse = 0;
    end else begin
      if (!frame_valid) begin
        chk_eq("outhigh_hold", outhigh, prev_oh);
        chk_eq("data_out_hold", data_out, prev_dv);
      end
      if (frame_valid || frame_err) begin
        chk_eq("pulse_exclusive", frame_valid & frame_err, 0);
        chk_eq("pulse_one_cycle", prev_pulse, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: actual valid=%0b err=%0b required none", frame_valid, frame_err);
        end else begin
          e  = exp_q.pop_front();
          eo = e.have ? (OW'(1) << e.val) : '0;
          chk_eq("pulse_kind_err", frame_err, e.err);
          chk_eq("data_out", data_out, e.val);
          chk_eq("outhigh", outhigh, eo);
          if (frame_valid) begin
            lat = ($time - t_sda_rise) / 10;
            chk_eq("valid_latency", lat, SYNC + 1);
          end
          if (frame_err && to_check) begin
            lat = ($time - t_scl) / 10;
            n_checks++;
            if (lat < TIMEOUT + SYNC || lat > TIMEOUT + SYNC + 2) begin
              n_fail++;
              $display("FAIL timeout_latency: actual %0d required %0d..%0d", lat, TIMEOUT + SYNC, TIMEOUT + SYNC + 2);
            end
            to_check = 0;
          end
        end
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
      end
      prev_oh    = outhigh;
      prev_dv    = data_out;
      prev_pulse = frame_valid | frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual time %0t required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  int nv0, ne0;

  initial begin
    rst = 1'b0;
    scl = 1'b1;
    sda = 1'b1;
    repeat (3) @(negedge sclk);
    chk_eq("rst_outhigh", outhigh, 0);
    chk_eq("rst_data_out", data_out, 0);
    chk_eq("rst_valid", frame_valid, 0);
    chk_eq("rst_err", frame_err, 0);
    chk_eq("rst_busy", busy, 0);
    rst = 1'b1;
    idle(5);

    // single frame 0xA, minimum scl phase
    p = 2;
    frame(4'hA, 0);
    idle(6);
    chk_eq("t1_outhigh", outhigh, 16'h0400);
    chk_eq("t1_data_out", data_out, 4'hA);
    chk_eq("t1_busy", busy, 0);

    // all sixteen codes back to back
    nv0 = n_valid;
    ne0 = n_err;
    for (int n = 0; n < OW; n++) begin
      p = $urandom_range(2, 4);
      frame(NBITS'(n), 0);
      idle(4);
    end
    idle(6);
    chk_eq("t2_valid_count", n_valid - nv0, OW);
    chk_eq("t2_err_count", n_err - ne0, 0);
    chk_eq("t2_outhigh", outhigh, 16'h8000);

    // premature STOP after two bits
    p = 3;
    frame(4'hA, 0);
    idle(6);
    ne0 = n_err;
    start_cond();
    send_bit(1);
    send_bit(1);
    stop_cond();
    idle(6);
    chk_eq("t3_err_count", n_err - ne0, 1);
    chk_eq("t3_outhigh", outhigh, 16'h0400);
    chk_eq("t3_data_out", data_out, 4'hA);
    chk_eq("t3_busy", busy, 0);

    // repeated START mid-frame, then a clean 0x5
    ne0 = n_err;
    start_cond();
    idle(1);
    chk_eq("t4_busy_open", busy, 1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    start_cond();
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    stop_cond();
    idle(6);
    chk_eq("t4_err_count", n_err - ne0, 1);
    chk_eq("t4_outhigh", outhigh, 16'h0020);
    chk_eq("t4_data_out", data_out, 4'h5);

    // inactivity abort with scl held high
    ne0 = n_err;
    start_cond();
    set_sda(1); hold();
    set_scl(1);
    to_check = 1;
    idle(300);
    chk_eq("t5_timeout_seen", to_check, 0);
    chk_eq("t5_err_count", n_err - ne0, 1);
    chk_eq("t5_busy", busy, 0);
    chk_eq("t5_outhigh_kept", outhigh, 16'h0020);
    to_check = 0;
    set_scl(0); hold();
    frame(4'hC, 1);
    idle(6);
    chk_eq("t5_next_outhigh", outhigh, 16'h1000);

    // reset in the middle of a frame
    frame(4'h3, 0);
    idle(6);
    chk_eq("t6_pre_outhigh", outhigh, 16'h0008);
    start_cond();
    send_bit(1);
    send_bit(0);
    @(negedge sclk);
    rst = 1'b0;
    scl = 1'b1;
    sda = 1'b1;
    since_scl = 0;
    m_open = 0;
    m_have = 0;
    m_last = '0;
    #1;
    chk_eq("t6_rst_outhigh", outhigh, 0);
    chk_eq("t6_rst_data_out", data_out, 0);
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_no_pending", exp_q.size(), 0);
    repeat (3) @(negedge sclk);
    rst = 1'b1;
    idle(5);
    frame(4'hF, 0);
    idle(6);
    chk_eq("t6_outhigh", outhigh, 16'h8000);
    chk_eq("t6_data_out", data_out, 4'hF);

    // randomized mix of good frames, premature STOPs and restarts
    for (int k = 0; k < 24; k++) begin
      int kind;
      p    = $urandom_range(2, 4);
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: frame(NBITS'($urandom), $urandom_range(0, 2));
        2: begin
          start_cond();
          repeat ($urandom_range(0, NBITS - 2)) send_bit(1'($urandom_range(0, 1)));
          stop_cond();
        end
        default: begin
          start_cond();
          repeat ($urandom_range(0, NBITS - 1)) send_bit(1'($urandom_range(0, 1)));
          frame(NBITS'($urandom), $urandom_range(0, 2));
        end
      endcase
      idle($urandom_range(2, 8));
    end

    idle(20);
    chk_eq("queue_drained", exp_q.size(), 0);
    chk_eq("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
